// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the scoreboard core: FSM states, point values, team-index width.
package scoreboard_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        PAUSE      = 3'd2,
        SHOT_STOP  = 3'd3,
        PERIOD_END = 3'd4,
        GAME_END   = 3'd5
    } state_e;

    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;
    localparam logic [1:0] THREE = 2'd3;

    function automatic int unsigned calc_team_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scoreboard_core_countdown_mmss.sv
// Loadable mm:ss down-counter; holds at 00:00 and flags zero. Load wins over decrement.
module countdown_mmss #(
    parameter int unsigned MIN_W   = 7,
    parameter int unsigned SEC_W   = 6,
    parameter int unsigned RST_MIN = 0,
    parameter int unsigned RST_SEC = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [MIN_W-1:0] i_load_min,
    input  logic [SEC_W-1:0] i_load_sec,
    input  logic             i_dec,
    output logic [MIN_W-1:0] o_min,
    output logic [SEC_W-1:0] o_sec,
    output logic             o_zero
);

    logic [MIN_W-1:0] r_min;
    logic [SEC_W-1:0] r_sec;

    assign o_min  = r_min;
    assign o_sec  = r_sec;
    assign o_zero = (r_min == '0) && (r_sec == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_min <= MIN_W'(RST_MIN);
            r_sec <= SEC_W'(RST_SEC);
        end else if (i_load) begin
            r_min <= i_load_min;
            r_sec <= i_load_sec;
        end else if (i_dec && !o_zero) begin
            if (r_sec == '0) begin
                r_min <= r_min - MIN_W'(1);
                r_sec <= SEC_W'(59);
            end else begin
                r_sec <= r_sec - SEC_W'(1);
            end
        end
    end

endmodule

// File: rtl/scoreboard_core.sv
// Scoreboard core: N team scores, shot clock, mm:ss game clock, period FSM and buzzer.
// Optional SCORE_UNDO_EN adds an undo input backed by a one-deep last-score record.
module scoreboard_core
    import scoreboard_pkg::*;
#(
    parameter int unsigned NUM_TEAMS   = 2,
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned SHOT_SEC    = 24,
    parameter int unsigned GAME_MIN    = 10,
    parameter int unsigned NUM_PERIODS = 4,
    parameter int unsigned BUZZ_CYC    = 25000000,
    localparam int unsigned TEAM_W     = calc_team_w(NUM_TEAMS)
) (
    input  logic                         i_clk,
    input  logic                         i_sys_rst,
    input  logic                         i_tick_1hz,
    input  logic                         i_run_en,
    input  logic                         i_shot_reset,
    input  logic                         i_period_adv,
    input  logic                         i_clear_all,
    input  logic                         i_score_valid,
    input  logic [TEAM_W-1:0]            i_score_team,
    input  logic [1:0]                   i_score_pts,
`ifdef SCORE_UNDO_EN
    input  logic                         i_undo,
`endif
    output logic [NUM_TEAMS*SCORE_W-1:0] o_scores,
    output logic [6:0]                   o_shot_cnt,
    output logic [6:0]                   o_game_min,
    output logic [5:0]                   o_game_sec,
    output logic [3:0]                   o_period,
    output logic [2:0]                   o_state,
    output logic                         o_shot_expired,
    output logic                         o_game_end,
    output logic                         o_buzzer,
    output logic                         o_score_err
);

    localparam int unsigned SUM_W  = SCORE_W + 1;
    localparam int unsigned BUZZ_W = $clog2(BUZZ_CYC + 1);

    state_e              r_state, w_state_next;
    logic [3:0]          r_period;
    logic [BUZZ_W-1:0]   r_buzz_cnt;
    logic [SCORE_W-1:0]  r_scores [NUM_TEAMS];
    logic [SCORE_W-1:0]  w_scores_next [NUM_TEAMS];
    logic                r_score_err, w_err, w_score_ok;
    logic [6:0]          w_game_min, w_shot_sec;
    logic [5:0]          w_game_sec;
    logic                w_shot_min, w_shot_zero, w_game_zero;
    logic [2:0]          w_unused_cd;

    logic w_run_tick, w_shot_rld, w_adv, w_game_hit, w_shot_hit;

    assign w_run_tick = (r_state == RUN) && i_tick_1hz;
    assign w_shot_rld = i_shot_reset && (r_state != GAME_END);
    assign w_adv      = i_period_adv && (r_state == PERIOD_END);
    assign w_game_hit = w_run_tick && (w_game_min == '0) && (w_game_sec == 6'd1);
    // Game-clock expiry masks a coincident shot expiry; a reload also cancels it.
    assign w_shot_hit = w_run_tick && !w_shot_rld && (w_shot_sec == 7'd1) && !w_game_hit;
    assign w_unused_cd = {w_shot_min, w_shot_zero, w_game_zero};

    countdown_mmss #(
        .MIN_W   (7),
        .SEC_W   (6),
        .RST_MIN (GAME_MIN),
        .RST_SEC (0)
    ) u_game_clk (
        .i_clk      (i_clk),
        .i_rst_n    (i_sys_rst),
        .i_load     (i_clear_all || w_adv),
        .i_load_min (7'(GAME_MIN)),
        .i_load_sec (6'd0),
        .i_dec      (w_run_tick),
        .o_min      (w_game_min),
        .o_sec      (w_game_sec),
        .o_zero     (w_game_zero)
    );

    countdown_mmss #(
        .MIN_W   (1),
        .SEC_W   (7),
        .RST_MIN (0),
        .RST_SEC (SHOT_SEC)
    ) u_shot_clk (
        .i_clk      (i_clk),
        .i_rst_n    (i_sys_rst),
        .i_load     (i_clear_all || w_shot_rld || w_adv),
        .i_load_min (1'b0),
        .i_load_sec (7'(SHOT_SEC)),
        .i_dec      (w_run_tick),
        .o_min      (w_shot_min),
        .o_sec      (w_shot_sec),
        .o_zero     (w_shot_zero)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:       if (i_run_en) w_state_next = RUN;
            RUN: begin
                if (w_game_hit) begin
                    w_state_next = (32'(r_period) < NUM_PERIODS) ? PERIOD_END : GAME_END;
                end else if (w_shot_hit) begin
                    w_state_next = SHOT_STOP;
                end else if (!i_run_en) begin
                    w_state_next = PAUSE;
                end
            end
            PAUSE:      if (i_run_en) w_state_next = RUN;
            SHOT_STOP:  if (i_shot_reset) w_state_next = PAUSE;
            PERIOD_END: if (i_period_adv) w_state_next = IDLE;
            GAME_END:   w_state_next = GAME_END;
            default:    w_state_next = IDLE;
        endcase
        if (i_clear_all) w_state_next = IDLE;
    end

`ifdef SCORE_UNDO_EN
    logic              r_undo_vld;
    logic [TEAM_W-1:0] r_undo_team;
    logic [1:0]        r_undo_amt, w_new_amt;
    logic              w_undo_ok;
`endif

    always_comb begin
        logic [SUM_W-1:0] v_sum;
        v_sum         = '0;
        w_scores_next = r_scores;
        w_err         = 1'b0;
`ifdef SCORE_UNDO_EN
        w_new_amt = 2'd0;
        w_undo_ok = i_undo && r_undo_vld && (r_state != GAME_END);
        if (i_undo && !w_undo_ok) w_err = 1'b1;
        for (int t = 0; t < int'(NUM_TEAMS); t++) begin
            if (w_undo_ok && (TEAM_W'(t) == r_undo_team)) begin
                w_scores_next[t] = (r_scores[t] > SCORE_W'(r_undo_amt)) ?
                                   r_scores[t] - SCORE_W'(r_undo_amt) : '0;
            end
        end
`endif
        w_score_ok = i_score_valid && (i_score_pts inside {ONE, TWO, THREE}) &&
                     (32'(i_score_team) < NUM_TEAMS) && (r_state != GAME_END);
        if (i_score_valid && !w_score_ok) w_err = 1'b1;
        // Score is added on top of any same-cycle undo result.
        for (int t = 0; t < int'(NUM_TEAMS); t++) begin
            if (w_score_ok && (TEAM_W'(t) == i_score_team)) begin
                v_sum = {1'b0, w_scores_next[t]} + SUM_W'(i_score_pts);
`ifdef SCORE_UNDO_EN
                w_new_amt = 2'(v_sum[SCORE_W] ? {SCORE_W{1'b1}} - w_scores_next[t]
                                              : SCORE_W'(i_score_pts));
`endif
                w_scores_next[t] = v_sum[SCORE_W] ? '1 : v_sum[SCORE_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_state     <= IDLE;
            r_period    <= 4'd1;
            r_buzz_cnt  <= '0;
            r_score_err <= 1'b0;
            for (int t = 0; t < int'(NUM_TEAMS); t++) r_scores[t] <= '0;
        end else if (i_clear_all) begin
            r_state     <= IDLE;
            r_period    <= 4'd1;
            r_buzz_cnt  <= '0;
            r_score_err <= 1'b0;
            for (int t = 0; t < int'(NUM_TEAMS); t++) r_scores[t] <= '0;
        end else begin
            r_state     <= w_state_next;
            r_score_err <= w_err;
            r_scores    <= w_scores_next;
            if (w_adv) r_period <= r_period + 4'd1;
            if (w_game_hit || w_shot_hit) begin
                r_buzz_cnt <= BUZZ_W'(BUZZ_CYC);
            end else if (r_buzz_cnt != '0) begin
                r_buzz_cnt <= r_buzz_cnt - BUZZ_W'(1);
            end
        end
    end

`ifdef SCORE_UNDO_EN
    always_ff @(posedge i_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_undo_vld  <= 1'b0;
            r_undo_team <= '0;
            r_undo_amt  <= 2'd0;
        end else if (i_clear_all) begin
            r_undo_vld  <= 1'b0;
        end else if (w_score_ok) begin
            r_undo_vld  <= 1'b1;
            r_undo_team <= i_score_team;
            r_undo_amt  <= w_new_amt;
        end else if (w_undo_ok) begin
            r_undo_vld  <= 1'b0;
        end
    end
`endif

    for (genvar g = 0; g < int'(NUM_TEAMS); g++) begin : g_scores
        assign o_scores[g*SCORE_W +: SCORE_W] = r_scores[g];
    end

    assign o_shot_cnt     = w_shot_sec;
    assign o_game_min     = w_game_min;
    assign o_game_sec     = w_game_sec;
    assign o_period       = r_period;
    assign o_state        = r_state;
    assign o_shot_expired = (r_state == SHOT_STOP);
    assign o_game_end     = (r_state == GAME_END);
    assign o_buzzer       = (r_buzz_cnt != '0);
    assign o_score_err    = r_score_err;

endmodule

// File: tb/tb_scoreboard_core.sv
// Scoreboard-style bench for scoreboard_core: stimulus queues expected values, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_scoreboard_core;

    localparam int NT = 3, SW = 8, SHOT = 24, GMIN = 1, NP = 2, BZ = 6;
    localparam int S_STATE = 0, S_SHOT = 1, S_MIN = 2, S_SEC = 3, S_PER = 4;
    localparam int S_SEXP = 5, S_GEND = 6, S_BUZZ = 7, S_ERR = 8, S_SCORE = 10;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_SHOT = 3, ST_PEND = 4, ST_GEND = 5;

    logic clk = 1'b0, rst_n = 1'b0;
    logic tick = 1'b0, run_en = 1'b0, shot_reset = 1'b0, period_adv = 1'b0;
    logic clear_all = 1'b0, score_valid = 1'b0;
    logic [1:0] team = 2'd0, pts = 2'd0;
`ifdef SCORE_UNDO_EN
    logic undo = 1'b0;
`endif
    logic [NT*SW-1:0] scores;
    logic [6:0] shot_cnt, game_min;
    logic [5:0] game_sec;
    logic [3:0] period;
    logic [2:0] state;
    logic shot_expired, game_end, buzzer, score_err;

    scoreboard_core #(
        .NUM_TEAMS   (NT),
        .SCORE_W     (SW),
        .SHOT_SEC    (SHOT),
        .GAME_MIN    (GMIN),
        .NUM_PERIODS (NP),
        .BUZZ_CYC    (BZ)
    ) dut (
        .i_clk          (clk),
        .i_sys_rst      (rst_n),
        .i_tick_1hz     (tick),
        .i_run_en       (run_en),
        .i_shot_reset   (shot_reset),
        .i_period_adv   (period_adv),
        .i_clear_all    (clear_all),
        .i_score_valid  (score_valid),
        .i_score_team   (team),
        .i_score_pts    (pts),
`ifdef SCORE_UNDO_EN
        .i_undo         (undo),
`endif
        .o_scores       (scores),
        .o_shot_cnt     (shot_cnt),
        .o_game_min     (game_min),
        .o_game_sec     (game_sec),
        .o_period       (period),
        .o_state        (state),
        .o_shot_expired (shot_expired),
        .o_game_end     (game_end),
        .o_buzzer       (buzzer),
        .o_score_err    (score_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } chk_t;

    chk_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int probe(input int sel);
        case (sel)
            S_STATE: return int'(state);
            S_SHOT:  return int'(shot_cnt);
            S_MIN:   return int'(game_min);
            S_SEC:   return int'(game_sec);
            S_PER:   return int'(period);
            S_SEXP:  return int'(shot_expired);
            S_GEND:  return int'(game_end);
            S_BUZZ:  return int'(buzzer);
            S_ERR:   return int'(score_err);
            default: return int'(scores[(sel-S_SCORE)*SW +: SW]);
        endcase
    endfunction

    always @(negedge clk) begin
        chk_t c;
        int   got;
        while (exp_q.size() > 0) begin
            c   = exp_q.pop_front();
            got = probe(c.sel);
            n_cmp++;
            if (got != c.exp) begin
                n_bad++;
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", c.name, got, c.exp, $time);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int sel, input int v);
        chk_t c;
        c.name = nm;
        c.sel  = sel;
        c.exp  = v;
        exp_q.push_back(c);
    endtask

    // Each tick is preceded by an idle cycle so it is a genuine single-cycle pulse.
    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b0;
            step(1);
            tick = 1'b1;
            step(1);
        end
        tick = 1'b0;
    endtask

    task automatic score(input int t, input int p);
        team        = 2'(t);
        pts         = 2'(p);
        score_valid = 1'b1;
        step(1);
        score_valid = 1'b0;
    endtask

    task automatic pulse_shot_reset();
        shot_reset = 1'b1;
        step(1);
        shot_reset = 1'b0;
    endtask

`ifdef SCORE_UNDO_EN
    task automatic pulse_undo();
        undo = 1'b1;
        step(1);
        undo = 1'b0;
    endtask
`endif

    initial begin
        step(2);
        rst_n = 1'b1;
        chk("rst_state", S_STATE, ST_IDLE);
        chk("rst_shot", S_SHOT, SHOT);
        chk("rst_min", S_MIN, GMIN);
        chk("rst_sec", S_SEC, 0);
        chk("rst_period", S_PER, 1);
        chk("rst_sexp", S_SEXP, 0);
        chk("rst_gend", S_GEND, 0);
        chk("rst_buzz", S_BUZZ, 0);
        chk("rst_err", S_ERR, 0);
        for (int t = 0; t < NT; t++) chk("rst_score", S_SCORE + t, 0);
        step(1);

        // Team 1 up to 254 (84 x 3 + 2), then saturation at 255.
        team = 2'd1; pts = 2'd3; score_valid = 1'b1;
        step(84);
        pts = 2'd2;
        step(1);
        score_valid = 1'b0;
        chk("score1_254", S_SCORE + 1, 254);
        score(1, 3);
        chk("score1_sat", S_SCORE + 1, 255);
        chk("score_ok_noerr", S_ERR, 0);
        score(1, 3);
        chk("score1_hold", S_SCORE + 1, 255);
        score(0, 0);
        chk("pts0_err", S_ERR, 1);
        chk("pts0_s0", S_SCORE + 0, 0);
        chk("pts0_s1", S_SCORE + 1, 255);
        step(1);
        chk("err_one_cycle", S_ERR, 0);
        score(3, 1);
        chk("team3_err", S_ERR, 1);
        chk("team3_s2", S_SCORE + 2, 0);
        score(2, 1);
        chk("team2_add", S_SCORE + 2, 1);
        score(0, 2);
        chk("team0_add", S_SCORE + 0, 2);

`ifdef SCORE_UNDO_EN
        pulse_undo();
        chk("undo_s0", S_SCORE + 0, 0);
        chk("undo_noerr", S_ERR, 0);
        pulse_undo();
        chk("undo2_err", S_ERR, 1);
        chk("undo2_s0", S_SCORE + 0, 0);
        score(0, 2);
        chk("readd_s0", S_SCORE + 0, 2);
        team = 2'd0; pts = 2'd3; score_valid = 1'b1; undo = 1'b1;
        step(1);
        score_valid = 1'b0; undo = 1'b0;
        chk("undo_then_add", S_SCORE + 0, 3);
        pulse_undo();
        chk("undo_last", S_SCORE + 0, 0);
        score(0, 2);
        chk("restore_s0", S_SCORE + 0, 2);
`endif

        // Shot-clock expiry.
        run_en = 1'b1;
        step(1);
        chk("run", S_STATE, ST_RUN);
        ticks(23);
        chk("shot_1", S_SHOT, 1);
        chk("game_37", S_SEC, 37);
        chk("game_min0", S_MIN, 0);
        ticks(1);
        chk("shot_0", S_SHOT, 0);
        chk("shot_stop", S_STATE, ST_SHOT);
        chk("sexp_1", S_SEXP, 1);
        chk("game_36", S_SEC, 36);
        chk("buzz_0", S_BUZZ, 1);
        for (int i = 1; i < BZ; i++) begin
            step(1);
            chk("buzz_on", S_BUZZ, 1);
        end
        step(1);
        chk("buzz_off", S_BUZZ, 0);
        ticks(2);
        chk("stop_hold_shot", S_SHOT, 0);
        chk("stop_hold_game", S_SEC, 36);
        pulse_shot_reset();
        chk("rld_shot", S_SHOT, SHOT);
        chk("rld_pause", S_STATE, ST_PAUSE);
        chk("rld_sexp", S_SEXP, 0);
        step(1);
        chk("resume", S_STATE, ST_RUN);

        // Shot and game clocks hit zero on the same tick.
        ticks(12);
        chk("g24", S_SEC, 24);
        chk("s12", S_SHOT, 12);
        pulse_shot_reset();
        chk("s_rld_run", S_SHOT, SHOT);
        chk("s_rld_state", S_STATE, ST_RUN);
        ticks(24);
        chk("both0_state", S_STATE, ST_PEND);
        chk("both0_sexp", S_SEXP, 0);
        chk("both0_sec", S_SEC, 0);
        chk("both0_min", S_MIN, 0);
        chk("both0_buzz", S_BUZZ, 1);
        ticks(1);
        chk("pend_hold", S_STATE, ST_PEND);
        period_adv = 1'b1;
        step(1);
        period_adv = 1'b0;
        chk("adv_period", S_PER, 2);
        chk("adv_min", S_MIN, GMIN);
        chk("adv_sec", S_SEC, 0);
        chk("adv_shot", S_SHOT, SHOT);
        chk("adv_idle", S_STATE, ST_IDLE);
        step(1);
        chk("p2_run", S_STATE, ST_RUN);
        period_adv = 1'b1;
        step(1);
        period_adv = 1'b0;
        chk("adv_ignored", S_PER, 2);

        // Reload coincident with a tick at shot_cnt 5.
        ticks(19);
        chk("s5", S_SHOT, 5);
        chk("g41", S_SEC, 41);
        step(1);
        tick = 1'b1; shot_reset = 1'b1;
        step(1);
        tick = 1'b0; shot_reset = 1'b0;
        chk("rld_wins", S_SHOT, SHOT);
        chk("rld_g40", S_SEC, 40);

        // Last period runs out: game over.
        ticks(20);
        chk("g20", S_SEC, 20);
        pulse_shot_reset();
        ticks(20);
        chk("gend_state", S_STATE, ST_GEND);
        chk("gend_flag", S_GEND, 1);
        chk("gend_sexp", S_SEXP, 0);
        chk("gend_shot", S_SHOT, 4);
        score(0, 1);
        chk("gend_score_err", S_ERR, 1);
        chk("gend_score_s0", S_SCORE + 0, 2);
        pulse_shot_reset();
        chk("gend_shot_hold", S_SHOT, 4);
        chk("gend_stay", S_STATE, ST_GEND);
`ifdef SCORE_UNDO_EN
        pulse_undo();
        chk("gend_undo_err", S_ERR, 1);
`endif
        chk("gend_buzz", S_BUZZ, 1);
        clear_all = 1'b1; run_en = 1'b0;
        step(1);
        clear_all = 1'b0;
        chk("clr_state", S_STATE, ST_IDLE);
        chk("clr_gend", S_GEND, 0);
        chk("clr_buzz", S_BUZZ, 0);
        chk("clr_period", S_PER, 1);
        chk("clr_shot", S_SHOT, SHOT);
        chk("clr_min", S_MIN, GMIN);
        chk("clr_sec", S_SEC, 0);
        for (int t = 0; t < NT; t++) chk("clr_score", S_SCORE + t, 0);
`ifdef SCORE_UNDO_EN
        pulse_undo();
        chk("clr_undo_err", S_ERR, 1);
`endif
        step(2);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
